// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// csr_trap_ctrl : trap/mret sequencer and CSR write-port arbiter (M-mode)
// Revision      : 1.0
// ============================================================================
module csr_trap_ctrl #(
    parameter int          XLEN     = 32,
    parameter int          CSR_AW   = 12,
    parameter logic [1:0]  MPP_MODE = 2'b11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              timer_irq_i,
    input  logic              ext_irq_i,
    input  logic              mret_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              pipe_csr_wr_i,
    input  logic [CSR_AW-1:0] pipe_csr_addr_i,
    input  logic [XLEN-1:0]   pipe_csr_wdata_i,
    output logic              pipe_csr_ack_o,
    input  logic [XLEN-1:0]   csr_mstatus_i,
    input  logic [XLEN-1:0]   csr_mie_i,
    input  logic [XLEN-1:0]   csr_mtvec_i,
    input  logic [XLEN-1:0]   csr_mepc_i,
    output logic              csr_wr_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_T_EPC    = 3'd1;
    localparam logic [2:0] c_ST_T_CAUSE  = 3'd2;
    localparam logic [2:0] c_ST_T_STATUS = 3'd3;
    localparam logic [2:0] c_ST_T_REDIR  = 3'd4;
    localparam logic [2:0] c_ST_M_STATUS = 3'd5;
    localparam logic [2:0] c_ST_M_REDIR  = 3'd6;

    localparam logic [CSR_AW-1:0] c_ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] c_ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] c_ADDR_MCAUSE  = CSR_AW'(12'h342);

    localparam logic [XLEN-1:0] c_CAUSE_EXT   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    localparam logic [XLEN-1:0] c_CAUSE_TIMER = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;

    logic            w_ext_take;
    logic            w_timer_take;
    logic            w_irq_take;
    logic [XLEN-1:0] w_irq_cause;
    logic [XLEN-1:0] w_trap_status;
    logic [XLEN-1:0] w_mret_status;
    logic [XLEN-1:0] w_vec_base;
    logic [XLEN-1:0] w_vec_offset;
    logic [XLEN-1:0] w_trap_target;
    logic            w_unused;

    assign w_ext_take   = csr_mstatus_i[3] & csr_mie_i[11] & ext_irq_i;
    assign w_timer_take = csr_mstatus_i[3] & csr_mie_i[7]  & timer_irq_i;
    assign w_irq_take   = w_ext_take | w_timer_take;
    assign w_irq_cause  = w_ext_take ? c_CAUSE_EXT : c_CAUSE_TIMER;

    assign w_vec_base    = {csr_mtvec_i[XLEN-1:2], 2'b00};
    assign w_vec_offset  = {{(XLEN-7){1'b0}}, r_cause[4:0], 2'b00};
    assign w_trap_target = csr_mtvec_i[0] ? (w_vec_base + w_vec_offset) : w_vec_base;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- MPP_MODE; other bits untouched.
    always_comb begin
        w_trap_status        = csr_mstatus_i;
        w_trap_status[7]     = csr_mstatus_i[3];
        w_trap_status[3]     = 1'b0;
        w_trap_status[12:11] = MPP_MODE;
    end

    // mret: MIE <- MPIE, MPIE <- 1, MPP <- 0.
    always_comb begin
        w_mret_status        = csr_mstatus_i;
        w_mret_status[3]     = csr_mstatus_i[7];
        w_mret_status[7]     = 1'b1;
        w_mret_status[12:11] = 2'b00;
    end

    assign w_unused = &{1'b0, csr_mtvec_i[1], csr_mie_i[XLEN-1:12], csr_mie_i[10:8],
                        csr_mie_i[6:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_epc   <= '0;
            r_cause <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // A pipeline CSR write defers mret/irq to the next cycle so
                    // they see the freshly written CSR values.
                    if (pipe_csr_wr_i) begin
                        r_state <= c_ST_IDLE;
                    end else if (mret_i) begin
                        r_state <= c_ST_M_STATUS;
                    end else if (w_irq_take) begin
                        r_epc   <= pc_i;
                        r_cause <= w_irq_cause;
                        r_state <= c_ST_T_EPC;
                    end
                end
                c_ST_T_EPC:    r_state <= c_ST_T_CAUSE;
                c_ST_T_CAUSE:  r_state <= c_ST_T_STATUS;
                c_ST_T_STATUS: r_state <= c_ST_T_REDIR;
                c_ST_T_REDIR:  r_state <= c_ST_IDLE;
                c_ST_M_STATUS: r_state <= c_ST_M_REDIR;
                c_ST_M_REDIR:  r_state <= c_ST_IDLE;
                default:       r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_csr_ack_o = 1'b0;
        csr_wr_o       = 1'b0;
        csr_waddr_o    = '0;
        csr_wdata_o    = '0;
        stall_o        = 1'b1;
        flush_o        = 1'b0;
        redirect_o     = 1'b0;
        redirect_pc_o  = '0;
        case (r_state)
            c_ST_IDLE: begin
                stall_o = 1'b0;
                if (pipe_csr_wr_i) begin
                    pipe_csr_ack_o = 1'b1;
                    csr_wr_o       = 1'b1;
                    csr_waddr_o    = pipe_csr_addr_i;
                    csr_wdata_o    = pipe_csr_wdata_i;
                end
            end
            c_ST_T_EPC: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = c_ADDR_MEPC;
                csr_wdata_o = r_epc;
            end
            c_ST_T_CAUSE: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = c_ADDR_MCAUSE;
                csr_wdata_o = r_cause;
            end
            c_ST_T_STATUS: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = c_ADDR_MSTATUS;
                csr_wdata_o = w_trap_status;
            end
            c_ST_T_REDIR: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = w_trap_target;
            end
            c_ST_M_STATUS: begin
                csr_wr_o    = 1'b1;
                csr_waddr_o = c_ADDR_MSTATUS;
                csr_wdata_o = w_mret_status;
            end
            c_ST_M_REDIR: begin
                flush_o       = 1'b1;
                redirect_o    = 1'b1;
                redirect_pc_o = csr_mepc_i;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
